lcd_spi_sequencer: RTL and testbench
====================================

LCD_SPI_SEQUENCER -- requirements
Module: lcd_spi_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning the number of clock cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter PAGES, default 8, meaning the number of display pages (legal range 1..16).
REQ-003 SHALL have parameter COLS, default 128, meaning the number of columns per page (legal range 1..256).
REQ-004 SHALL have parameter RST_CYCLES, default 32, meaning the number of cycles res_n is held low after reset.
REQ-005 clock  in  1  system clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 wr_valid  in  1  byte-write request.
REQ-008 wr_ready  out  1  high only in IDLE; a transfer is accepted when wr_valid && wr_ready.
REQ-009 wr_page  in  4  target page.
REQ-010 wr_col  in  8  target column.
REQ-011 wr_data  in  8  pixel byte, LSB at top.
REQ-012 clr_req  in  1  full-screen clear request, sampled in IDLE.
REQ-013 top_line  in  6  display start line, sent before every write or clear.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err  out  1  one-cycle pulse on an out-of-range request.
REQ-016 res_n  out  1  LCD reset, active-low.
REQ-017 a0  out  1  0 for command bytes, 1 for data bytes.
REQ-018 led_a  out  1  backlight.
REQ-019 cs_n  out  1  chip select, active-low.
REQ-020 sclk  out  1  serial clock.
REQ-021 sdata  out  1  serial data.

Function
REQ-022 SHALL implement states RST_HOLD, INIT, IDLE, CMD_START, CMD_PAGE, CMD_COLHI, CMD_COLLO, DATA and CLR_DATA.
REQ-023 Serializer: each byte is sent MSB first; cs_n falls one cycle before the first SCLK edge and rises one cycle after the last.
REQ-024 Serializer timing: sclk idles low; sdata changes only while sclk is low; each bit lasts 2*CLK_DIV cycles.
REQ-025 Serializer framing: bytes are separated by at least 2 cycles with cs_n high; a0 is stable while cs_n is low.
REQ-026 RST_HOLD: res_n=0 for RST_CYCLES cycles, then res_n=1 and the block moves to INIT; led_a=1 from INIT onward.
REQ-027 INIT: sends commands A2, A0, C8, 24, 81, 3F, 2F, AF (hex) in that order with a0=0, then moves to IDLE.
REQ-028 IDLE precedence: clr_req beats wr_valid in the same cycle; a write presented with clr_req is not accepted and stays pending.
REQ-029 Accepted write: page, column and data are latched; sequence is CMD_START (0x40|top_line), CMD_PAGE (0xB0|page), CMD_COLHI (0x10|col[7:4]), CMD_COLLO (0x00|col[3:0]), then DATA (wr_data, a0=1), then IDLE.
REQ-030 Range check: a request with wr_page>=PAGES or wr_col>=COLS is accepted, produces no serial activity, pulses err for one cycle and returns to IDLE the next cycle.
REQ-031 Clear: for each page 0..PAGES-1, send CMD_START with top_line forced to 0, then CMD_PAGE, CMD_COLHI=0x10 and CMD_COLLO=0x00, then COLS bytes of 0x00 with a0=1; return to IDLE after the last page.
REQ-032 Counters: the clear page counter is 4 bits and the column counter is 9 bits; no wrap past PAGES-1 or COLS-1.
REQ-033 No input other than reset shall abort a write or clear in progress.
REQ-034 top_line is sampled once per sequence when CMD_START is loaded.
REQ-035 Minimum latency from acceptance to the first cs_n fall is 2 cycles.

Reset
REQ-036 While reset=1: state=RST_HOLD; res_n=0, cs_n=1, sclk=0, sdata=0, a0=0, led_a=0, busy=1, wr_ready=0, err=0; all counters cleared.
REQ-037 Reset asserted mid-byte ends the transfer in the same cycle (cs_n=1) and the full init sequence reruns.

Verification
REQ-038 Reset release, CLK_DIV=1 -> res_n low for 32 cycles; 8 init bytes A2..AF decoded from sdata on sclk rise; wr_ready=1 afterwards.
REQ-039 Write page=3, col=0x25, data=0x5A, top_line=0 -> bytes 40, B3, 12, 05, then 5A with a0=1; wr_ready returns.
REQ-040 clr_req with PAGES=2, COLS=4 -> 2x(40, Bp, 10, 00, then four 00 data bytes); busy throughout.
REQ-041 wr_page=8 with PAGES=8 -> err pulses once; cs_n stays high; wr_ready=1 two cycles after acceptance.
REQ-042 clr_req and wr_valid in the same cycle -> clear runs first, then the write; reset in mid-DATA -> cs_n=1 immediately and init repeats.
REQ-043 CLK_DIV=3 -> each sclk half-period measures 3 cycles; sdata never toggles while sclk=1.

Source files
------------

// File: rtl/lcd_spi_sequencer.sv
// lcd_spi_sequencer: drives an ST7565-style LCD over a write-only SPI link.
// Holds the panel in reset, sends the init command list, then serves single
// byte writes (start line, page, column address, data) and full-screen clears.
module lcd_spi_sequencer #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned PAGES      = 8,
   parameter int unsigned COLS       = 128,
   parameter int unsigned RST_CYCLES = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [3:0] wr_page,
   input  logic [7:0] wr_col,
   input  logic [7:0] wr_data,
   input  logic       clr_req,
   input  logic [5:0] top_line,
   output logic       busy,
   output logic       err,
   output logic       res_n,
   output logic       a0,
   output logic       led_a,
   output logic       cs_n,
   output logic       sclk,
   output logic       sdata
);

   localparam int unsigned   RW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [4:0]    PAGES_W   = 5'(PAGES);
   localparam logic [3:0]    PAGE_LAST = 4'(PAGES - 1);
   localparam logic [8:0]    COLS_W    = 9'(COLS);
   localparam logic [8:0]    COL_LAST  = 9'(COLS - 1);

   typedef enum logic [3:0] {
      RST_HOLD,
      INIT,
      IDLE,
      CMD_START,
      CMD_PAGE,
      CMD_COLHI,
      CMD_COLLO,
      DATA,
      CLR_DATA,
      RANGE_ERR
   } state_t;

   typedef enum logic [2:0] {
      SP_IDLE,
      SP_LOW,
      SP_HIGH,
      SP_TRAIL,
      SP_GAP
   } ser_t;

   // Sequencer registers
   state_t          state_q, state_d;
   logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
   logic [2:0]      init_idx_q, init_idx_d;
   logic            clr_q, clr_d;
   logic [3:0]      pg_q, pg_d;
   logic [8:0]      col_cnt_q, col_cnt_d;
   logic [3:0]      page_q, page_d;
   logic [7:0]      col_q, col_d;
   logic [7:0]      data_q, data_d;

   // Serializer registers
   ser_t            ser_q, ser_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      div_q, div_d;
   logic            first_q, first_d;
   logic            a0_q, a0_d;

   // Sequencer/serializer handshake
   logic            ser_start;
   logic            ser_done;
   logic [7:0]      ser_byte;
   logic            ser_a0;
   logic            oor;
   logic            cs_int;

   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      logic [7:0] b;
      unique case (idx)
         3'd0:    b = 8'hA2;
         3'd1:    b = 8'hA0;
         3'd2:    b = 8'hC8;
         3'd3:    b = 8'h24;
         3'd4:    b = 8'h81;
         3'd5:    b = 8'h3F;
         3'd6:    b = 8'h2F;
         default: b = 8'hAF;
      endcase
      return b;
   endfunction

   assign ser_done = (ser_q == SP_GAP);
   assign oor      = ({1'b0, wr_page} >= PAGES_W) || ({1'b0, wr_col} >= COLS_W);

   // Sequencer next state: byte selection for the current step and step ordering
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      init_idx_d = init_idx_q;
      clr_d      = clr_q;
      pg_d       = pg_q;
      col_cnt_d  = col_cnt_q;
      page_d     = page_q;
      col_d      = col_q;
      data_d     = data_q;
      ser_byte   = '0;
      ser_a0     = 1'b0;

      unique case (state_q)
         INIT:      ser_byte = init_byte(init_idx_q);
         CMD_START: ser_byte = {2'b01, clr_q ? 6'd0 : top_line};
         CMD_PAGE:  ser_byte = {4'hB, clr_q ? pg_q : page_q};
         CMD_COLHI: ser_byte = {4'h1, clr_q ? 4'h0 : col_q[7:4]};
         CMD_COLLO: ser_byte = {4'h0, clr_q ? 4'h0 : col_q[3:0]};
         DATA: begin
            ser_byte = data_q;
            ser_a0   = 1'b1;
         end
         CLR_DATA:  ser_a0 = 1'b1;
         default:   ser_byte = '0;
      endcase

      // Every byte-sending state kicks the serializer whenever it is free;
      // the state then advances on the serializer's done cycle.
      ser_start = (ser_q == SP_IDLE) &&
                  (state_q inside {INIT, CMD_START, CMD_PAGE, CMD_COLHI,
                                   CMD_COLLO, DATA, CLR_DATA});

      unique case (state_q)
         RST_HOLD: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d    = INIT;
               init_idx_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RW'(1);
            end
         end
         INIT: begin
            if (ser_done) begin
               if (init_idx_q == 3'd7) begin
                  state_d = IDLE;
               end else begin
                  init_idx_d = init_idx_q + 3'd1;
               end
            end
         end
         IDLE: begin
            if (clr_req) begin
               clr_d     = 1'b1;
               pg_d      = '0;
               col_cnt_d = '0;
               state_d   = CMD_START;
            end else if (wr_valid) begin
               clr_d  = 1'b0;
               page_d = wr_page;
               col_d  = wr_col;
               data_d = wr_data;
               state_d = oor ? RANGE_ERR : CMD_START;
            end
         end
         RANGE_ERR: state_d = IDLE;
         CMD_START: if (ser_done) state_d = CMD_PAGE;
         CMD_PAGE:  if (ser_done) state_d = CMD_COLHI;
         CMD_COLHI: if (ser_done) state_d = CMD_COLLO;
         CMD_COLLO: if (ser_done) state_d = clr_q ? CLR_DATA : DATA;
         DATA:      if (ser_done) state_d = IDLE;
         CLR_DATA: begin
            if (ser_done) begin
               if (col_cnt_q == COL_LAST) begin
                  col_cnt_d = '0;
                  if (pg_q == PAGE_LAST) begin
                     clr_d   = 1'b0;
                     state_d = IDLE;
                  end else begin
                     pg_d    = pg_q + 4'd1;
                     state_d = CMD_START;
                  end
               end else begin
                  col_cnt_d = col_cnt_q + 9'd1;
               end
            end
         end
         default: state_d = RST_HOLD;
      endcase
   end

   // Serializer next state: MSB-first bits, CLK_DIV cycles per sclk half
   always_comb begin
      ser_d   = ser_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      div_d   = div_q;
      first_d = first_q;
      a0_d    = a0_q;

      unique case (ser_q)
         SP_IDLE: begin
            if (ser_start) begin
               shift_d = ser_byte;
               a0_d    = ser_a0;
               bit_d   = 3'd7;
               div_d   = '0;
               first_d = 1'b1;
               ser_d   = SP_LOW;
            end
         end
         SP_LOW: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               first_d = 1'b0;
               ser_d   = SP_HIGH;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         SP_HIGH: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (bit_q == 3'd0) begin
                  ser_d = SP_TRAIL;
               end else begin
                  shift_d = {shift_q[6:0], 1'b0};
                  bit_d   = bit_q - 3'd1;
                  ser_d   = SP_LOW;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         SP_TRAIL: ser_d = SP_GAP;
         SP_GAP:   ser_d = SP_IDLE;
         default:  ser_d = SP_IDLE;
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RST_HOLD;
         rst_cnt_q  <= '0;
         init_idx_q <= '0;
         clr_q      <= 1'b0;
         pg_q       <= '0;
         col_cnt_q  <= '0;
         page_q     <= '0;
         col_q      <= '0;
         data_q     <= '0;
         ser_q      <= SP_IDLE;
         shift_q    <= '0;
         bit_q      <= '0;
         div_q      <= '0;
         first_q    <= 1'b0;
         a0_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         init_idx_q <= init_idx_d;
         clr_q      <= clr_d;
         pg_q       <= pg_d;
         col_cnt_q  <= col_cnt_d;
         page_q     <= page_d;
         col_q      <= col_d;
         data_q     <= data_d;
         ser_q      <= ser_d;
         shift_q    <= shift_d;
         bit_q      <= bit_d;
         div_q      <= div_d;
         first_q    <= first_d;
         a0_q       <= a0_d;
      end
   end

   // The first bit's MSB is presented with cs_n still high so that cs_n
   // falls exactly one cycle before the first rising sclk edge.
   assign cs_int = !(((ser_q == SP_LOW) && (!first_q || (div_q == DIV_LAST))) ||
                     (ser_q == SP_HIGH) || (ser_q == SP_TRAIL));

   // Outputs are forced to their reset values combinationally so that an
   // asserted reset cuts a byte off in the same cycle.
   assign res_n    = !reset && (state_q != RST_HOLD);
   assign led_a    = !reset && (state_q != RST_HOLD);
   assign busy     = reset || (state_q != IDLE);
   assign wr_ready = !reset && (state_q == IDLE) && !clr_req;
   assign err      = !reset && (state_q == RANGE_ERR);
   assign cs_n     = reset || cs_int;
   assign sclk     = !reset && (ser_q == SP_HIGH);
   assign sdata    = !reset && ((ser_q == SP_LOW) || (ser_q == SP_HIGH)) && shift_q[7];
   assign a0       = !reset && a0_q;

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Bench for lcd_spi_sequencer: two instances (fast divider with full-size
// screen, slow divider with a tiny screen); a serial decoder feeds a byte
// queue that is compared with a queue built from the command rules.
module tb_lcd_spi_sequencer;

   localparam int unsigned A_DIV = 1, A_PAGES = 8, A_COLS = 128, A_RST = 32;
   localparam int unsigned B_DIV = 3, B_PAGES = 2, B_COLS = 4,   B_RST = 8;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [1:0] rst;
   logic [1:0] wr_valid, clr_req;
   logic [3:0] wr_page [2];
   logic [7:0] wr_col  [2];
   logic [7:0] wr_data [2];
   logic [5:0] top_line[2];
   logic [1:0] wr_ready, busy, err, res_n, a0, led_a, cs_n, sclk, sdata;

   int nvec = 0;
   int nerr = 0;

   lcd_spi_sequencer #(.CLK_DIV(A_DIV), .PAGES(A_PAGES), .COLS(A_COLS), .RST_CYCLES(A_RST)) dut_a (
      .clock(clock), .reset(rst[0]), .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]),
      .wr_page(wr_page[0]), .wr_col(wr_col[0]), .wr_data(wr_data[0]), .clr_req(clr_req[0]),
      .top_line(top_line[0]), .busy(busy[0]), .err(err[0]), .res_n(res_n[0]), .a0(a0[0]),
      .led_a(led_a[0]), .cs_n(cs_n[0]), .sclk(sclk[0]), .sdata(sdata[0]));

   lcd_spi_sequencer #(.CLK_DIV(B_DIV), .PAGES(B_PAGES), .COLS(B_COLS), .RST_CYCLES(B_RST)) dut_b (
      .clock(clock), .reset(rst[1]), .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]),
      .wr_page(wr_page[1]), .wr_col(wr_col[1]), .wr_data(wr_data[1]), .clr_req(clr_req[1]),
      .top_line(top_line[1]), .busy(busy[1]), .err(err[1]), .res_n(res_n[1]), .a0(a0[1]),
      .led_a(led_a[1]), .cs_n(cs_n[1]), .sclk(sclk[1]), .sdata(sdata[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nvec++;
      if (obs !== exp_v) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int unsigned div_of(input int k);
      return (k == 0) ? A_DIV : B_DIV;
   endfunction
   function automatic int unsigned pages_of(input int k);
      return (k == 0) ? A_PAGES : B_PAGES;
   endfunction
   function automatic int unsigned cols_of(input int k);
      return (k == 0) ? A_COLS : B_COLS;
   endfunction

   // ---------------- reference model: expected {a0, byte} streams --------
   logic [8:0] got0[$], got1[$], exp0[$], exp1[$];

   function automatic void push(input int k, input logic [8:0] v);
      if (k == 0) exp0.push_back(v);
      else        exp1.push_back(v);
   endfunction

   function automatic void push_init(input int k);
      logic [7:0] tab [8];
      tab = '{8'hA2, 8'hA0, 8'hC8, 8'h24, 8'h81, 8'h3F, 8'h2F, 8'hAF};
      for (int i = 0; i < 8; i++) push(k, {1'b0, tab[i]});
   endfunction

   function automatic void push_cmds(input int k, input int tl, input int p, input int c);
      push(k, {1'b0, 8'(64 + tl)});
      push(k, {1'b0, 8'(176 + p)});
      push(k, {1'b0, 8'(16 + c / 16)});
      push(k, {1'b0, 8'(c % 16)});
   endfunction

   function automatic void push_clear(input int k);
      for (int p = 0; p < int'(pages_of(k)); p++) begin
         push_cmds(k, 0, p, 0);
         for (int c = 0; c < int'(cols_of(k)); c++) push(k, 9'h100);
      end
   endfunction

   // ---------------- serial decoder and link-timing observer -------------
   int         nb[2], run[2], cs_hi[2], cs_lo[2], since_fall[2], proto[2], last_hi[2];
   logic       psclk[2], psdata[2], pcs[2], pa0[2];
   logic [7:0] sh[2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         nb[k] = 0; run[k] = 0; cs_hi[k] = 2; cs_lo[k] = 0; since_fall[k] = 0;
         proto[k] = 0; last_hi[k] = 0; psclk[k] = 0; psdata[k] = 0; pcs[k] = 1;
         pa0[k] = 0; sh[k] = '0;
      end
   end

   always @(negedge clock) begin
      logic [7:0] nv;
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            nb[k] = 0; run[k] = 0; cs_hi[k] = 2; cs_lo[k] = 0; since_fall[k] = 0;
         end else begin
            since_fall[k]++;
            if (sclk[k] != psclk[k]) begin
               if (psclk[k]) begin
                  if (run[k] != int'(div_of(k))) proto[k]++;
                  last_hi[k]    = run[k];
                  since_fall[k] = 0;
               end else begin
                  if (nb[k] != 0 && run[k] != int'(div_of(k))) proto[k]++;
                  if (nb[k] == 0 && cs_lo[k] != 1) proto[k]++;
                  if (cs_n[k]) proto[k]++;
                  else begin
                     nv    = {sh[k][6:0], sdata[k]};
                     sh[k] = nv;
                     nb[k]++;
                     if (nb[k] == 8) begin
                        nb[k] = 0;
                        if (k == 0) got0.push_back({a0[k], nv});
                        else        got1.push_back({a0[k], nv});
                     end
                  end
               end
               run[k] = 1;
            end else begin
               run[k]++;
            end
            if (sclk[k] && psclk[k] && sdata[k] != psdata[k]) proto[k]++;
            if (!cs_n[k] && !pcs[k] && a0[k] != pa0[k]) proto[k]++;
            if (!cs_n[k] && pcs[k] && cs_hi[k] < 2) proto[k]++;
            if (cs_n[k] && !pcs[k] && (nb[k] != 0 || since_fall[k] != 1)) proto[k]++;
            cs_hi[k] = cs_n[k] ? cs_hi[k] + 1 : 0;
            cs_lo[k] = cs_n[k] ? 0 : cs_lo[k] + 1;
         end
         psclk[k] = sclk[k]; psdata[k] = sdata[k]; pcs[k] = cs_n[k]; pa0[k] = a0[k];
      end
   end

   // ---------------- helpers ---------------------------------------------
   task automatic wait_ready(input int k);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(wr_ready[k] && !busy[k]) && n < 6000);
      chk($sformatf("ready%0d", k), wr_ready[k] && !busy[k], 1);
   endtask

   task automatic cmp_stream(input int k, input string tag);
      logic [8:0] g[$];
      logic [8:0] e[$];
      if (k == 0) begin g = got0; e = exp0; got0.delete(); exp0.delete(); end
      else        begin g = got1; e = exp1; got1.delete(); exp1.delete(); end
      chk({tag, "_count"}, g.size(), e.size());
      for (int i = 0; i < g.size() && i < e.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), 32'(g[i]), 32'(e[i]));
   endtask

   task automatic count_low(input logic [1:0] which, output int l0, output int l1);
      int n = 0;
      l0 = 0; l1 = 0;
      do begin
         @(negedge clock);
         n++;
         if (which[0] && !res_n[0]) l0++;
         if (which[1] && !res_n[1]) l1++;
      end while (((res_n & which) != which) && n < 300);
   endtask

   task automatic do_write(input int k, input int p, input int c, input logic [7:0] d,
                           input logic [5:0] tl, input string tag);
      bit oor;
      int lat;
      oor = (p >= int'(pages_of(k))) || (c >= int'(cols_of(k)));
      if (!oor) begin
         push_cmds(k, int'(tl), p, c);
         push(k, {1'b1, d});
      end
      @(posedge clock); #1;
      wr_valid[k] = 1'b1; wr_page[k] = 4'(p); wr_col[k] = 8'(c);
      wr_data[k] = d; top_line[k] = tl;
      @(posedge clock); #1;
      wr_valid[k] = 1'b0;
      wr_page[k] = 4'($urandom); wr_col[k] = 8'($urandom); wr_data[k] = 8'($urandom);
      if (oor) begin
         @(negedge clock);
         chk({tag, "_err_pulse"}, {err[k], wr_ready[k], cs_n[k]}, 3'b101);
         @(negedge clock);
         chk({tag, "_err_end"}, {err[k], wr_ready[k], cs_n[k]}, 3'b011);
      end else begin
         lat = 1;
         @(negedge clock);
         while (cs_n[k] && lat < 100) begin
            lat++;
            @(negedge clock);
         end
         chk({tag, "_latency"}, lat >= 2 && lat < 100, 1);
      end
      wait_ready(k);
      cmp_stream(k, tag);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // ---------------- stimulus ----------------------------------------------
   initial begin
      int l0, l1;
      int n;
      rst = 2'b11; wr_valid = '0; clr_req = '0;
      for (int k = 0; k < 2; k++) begin
         wr_page[k] = '0; wr_col[k] = '0; wr_data[k] = '0; top_line[k] = '0;
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 2; k++)
         chk($sformatf("reset_outs%0d", k),
             {res_n[k], cs_n[k], sclk[k], sdata[k], a0[k], led_a[k], busy[k], wr_ready[k], err[k]},
             9'b0_1_0_0_0_0_1_0_0);

      @(posedge clock); #1;
      rst = 2'b00;
      count_low(2'b11, l0, l1);
      chk("res_low_a", l0, A_RST);
      chk("res_low_b", l1, B_RST);
      chk("led_a", led_a, 2'b11);
      push_init(0);
      push_init(1);
      wait_ready(0);
      wait_ready(1);
      cmp_stream(0, "init_a");
      cmp_stream(1, "init_b");

      // instance A: CLK_DIV=1, 8x128
      do_write(0, 3, 8'h25, 8'h5A, 6'd0, "wr_a");
      do_write(0, 8, 10, 8'h11, 6'd0, "page_oor_a");
      for (int i = 0; i < 10; i++)
         do_write(0, $urandom_range(0, 9), $urandom_range(0, 140), 8'($urandom),
                  6'($urandom), $sformatf("rnd_a%0d", i));

      // reset while the data byte is on the wire
      push_cmds(0, 7, 2, 9);
      @(posedge clock); #1;
      wr_valid[0] = 1'b1; wr_page[0] = 4'd2; wr_col[0] = 8'd9; wr_data[0] = 8'h99;
      top_line[0] = 6'd7;
      @(posedge clock); #1;
      wr_valid[0] = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(got0.size() == 4 && !cs_n[0]) && n < 500);
      chk("mid_data_reached", got0.size() == 4 && !cs_n[0], 1);
      repeat (4) @(negedge clock);
      @(posedge clock); #1;
      rst[0] = 1'b1;
      #1;
      chk("rst_mid_byte", {cs_n[0], sclk[0], busy[0], res_n[0]}, 4'b1010);
      repeat (2) @(posedge clock);
      #1;
      rst[0] = 1'b0;
      count_low(2'b01, l0, l1);
      chk("res_low_a2", l0, A_RST);
      push_init(0);
      wait_ready(0);
      cmp_stream(0, "reinit_a");
      chk("proto_a", proto[0], 0);
      chk("hi_half_a", last_hi[0], A_DIV);

      // instance B: CLK_DIV=3, 2x4
      push_clear(1);
      @(posedge clock); #1;
      clr_req[1] = 1'b1;
      @(posedge clock); #1;
      clr_req[1] = 1'b0;
      @(negedge clock);
      chk("clr_busy", {busy[1], wr_ready[1]}, 2'b10);
      wait_ready(1);
      cmp_stream(1, "clear_b");

      // clear and write presented together: clear first, write stays pending
      push_clear(1);
      push_cmds(1, 5, 1, 2);
      push(1, 9'h1C3);
      @(posedge clock); #1;
      clr_req[1] = 1'b1; wr_valid[1] = 1'b1;
      wr_page[1] = 4'd1; wr_col[1] = 8'd2; wr_data[1] = 8'hC3; top_line[1] = 6'd5;
      @(posedge clock); #1;
      clr_req[1] = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!wr_ready[1] && n < 6000);
      chk("pending_wr_ready", wr_ready[1], 1);
      @(posedge clock); #1;
      wr_valid[1] = 1'b0;
      wait_ready(1);
      cmp_stream(1, "clr_then_wr_b");

      do_write(1, 1, 4, 8'h77, 6'd1, "col_oor_b");
      do_write(1, 1, 3, 8'hE1, 6'd63, "wr_b");
      for (int i = 0; i < 6; i++)
         do_write(1, $urandom_range(0, 2), $urandom_range(0, 5), 8'($urandom),
                  6'($urandom), $sformatf("rnd_b%0d", i));
      chk("proto_b", proto[1], 0);
      chk("hi_half_b", last_hi[1], B_DIV);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
